// File: rtl/vdcm_pkg.sv
// Shared constants and helpers for the MPP quantizer and its decoder-side twin.
package vdcm_pkg;
    localparam int BIT_DEPTH   = 8;
    localparam int BLK_PIX     = 16;
    localparam int SSM_SAMPLES = 16;
    // ssm0 carries the first SSM0_PIX pixels of c0, then c1, then c2.
    localparam int SSM0_PIX    = 4;
    // ssm1..ssm3 each carry one component's remaining pixels, zero padded.
    localparam int SSMK_PIX    = BLK_PIX - SSM0_PIX;

    // Clamp x into [lo, hi]; wide enough for every intermediate of the quantizer.
    function automatic logic signed [10:0] clip3(input logic signed [10:0] lo,
                                                 input logic signed [10:0] hi,
                                                 input logic signed [10:0] x);
        if (x < lo) begin
            clip3 = lo;
        end else if (x > hi) begin
            clip3 = hi;
        end else begin
            clip3 = x;
        end
    endfunction
endpackage

// File: rtl/mpp_quant1.sv
// Single-component midpoint residual quantizer plus matching reconstruction.
module mpp_quant1
    import vdcm_pkg::*;
(
    input  logic [7:0] i_x,
    input  logic [7:0] i_mp,
    input  logic [2:0] i_step,
    output logic [7:0] o_q,
    output logic [7:0] o_rec
);
    logic signed [8:0]  w_r;
    logic [8:0]         w_abs;
    logic [9:0]         w_rnd;
    logic [9:0]         w_mag;
    logic [10:0]        w_lim;
    logic signed [10:0] w_qs;
    logic signed [10:0] w_lo;
    logic signed [10:0] w_hi;
    logic signed [10:0] w_qc;
    logic signed [10:0] w_recs;

    // Residual against the midpoint, magnitude rounded half-up before the shift.
    assign w_r   = $signed({1'b0, i_x}) - $signed({1'b0, i_mp});
    assign w_abs = w_r[8] ? (~w_r + 9'd1) : w_r;
    assign w_rnd = (i_step == 3'd0) ? 10'd0 : (10'd1 << (i_step - 3'd1));
    assign w_mag = ({1'b0, w_abs} + w_rnd) >> i_step;
    assign w_qs  = w_r[8] ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});

    // Signed (8-step)-bit range of the coded residual.
    assign w_lim = 11'd1 << (3'd7 - i_step);
    assign w_hi  = $signed(w_lim - 11'd1);
    assign w_lo  = -$signed(w_lim);
    assign w_qc  = clip3(w_lo, w_hi, w_qs);
    assign o_q   = w_qc[7:0];

    // Decoder-identical reconstruction; |q*2^step| <= 128 so 11 bits never overflow.
    assign w_recs = (w_qc <<< i_step) + $signed({3'b000, i_mp});
    assign o_rec  = 8'(clip3(11'sd0, 11'sd255, w_recs));
endmodule

// File: rtl/enc_mpp.sv
// Encoder MPP quantizer for one 8x2 block: per-pixel reconstruction and a
// per-block residual bundle split into the four MPP substreams.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// out_valid, once high, holds with stable bundle data until transferred.
// in_ready depends combinationally on out_ready (only at the last pixel).
module enc_mpp
    import vdcm_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int BLK_PIX   = 16
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_DEPTH-1:0] in_c0,
    input  logic [BIT_DEPTH-1:0] in_c1,
    input  logic [BIT_DEPTH-1:0] in_c2,
    input  logic [BIT_DEPTH-1:0] in_mp,
    input  logic [2:0]           in_step,
    output logic                 rec_valid,
    output logic [BIT_DEPTH-1:0] rec_c0,
    output logic [BIT_DEPTH-1:0] rec_c1,
    output logic [BIT_DEPTH-1:0] rec_c2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_DEPTH-1:0] mpp_qres_ssm0 [0:BLK_PIX-1],
    output logic [BIT_DEPTH-1:0] mpp_qres_ssm1 [0:BLK_PIX-1],
    output logic [BIT_DEPTH-1:0] mpp_qres_ssm2 [0:BLK_PIX-1],
    output logic [BIT_DEPTH-1:0] mpp_qres_ssm3 [0:BLK_PIX-1]
);
    localparam int CW = $clog2(BLK_PIX);
    localparam logic [CW-1:0] LAST = CW'(BLK_PIX - 1);

    logic [CW-1:0]  r_cnt;
    logic [7:0]     r_mp;
    logic [2:0]     r_step;
    logic           r_out_valid;
    logic [7:0]     r_wc0 [0:BLK_PIX-2];
    logic [7:0]     r_wc1 [0:BLK_PIX-2];
    logic [7:0]     r_wc2 [0:BLK_PIX-2];

    logic           w_acc;
    logic           w_last;
    logic [7:0]     w_mp;
    logic [2:0]     w_step;
    logic [7:0]     w_q0, w_q1, w_q2;
    logic [7:0]     w_rec0, w_rec1, w_rec2;
    logic [7:0]     w_m0 [0:BLK_PIX-1];
    logic [7:0]     w_m1 [0:BLK_PIX-1];
    logic [7:0]     w_m2 [0:BLK_PIX-1];
    logic [7:0]     w_s0 [0:SSM_SAMPLES-1];
    logic [7:0]     w_s1 [0:SSM_SAMPLES-1];
    logic [7:0]     w_s2 [0:SSM_SAMPLES-1];
    logic [7:0]     w_s3 [0:SSM_SAMPLES-1];

    // Only the last pixel of a block can stall, and only behind an unconsumed bundle.
    assign w_last    = (r_cnt == LAST);
    assign in_ready  = !(w_last && r_out_valid && !out_ready);
    assign w_acc     = in_valid && in_ready;
    assign out_valid = r_out_valid;

    // Pixel 0 carries the block parameters on the wire; later pixels use the latched copy.
    assign w_mp   = (r_cnt == '0) ? in_mp   : r_mp;
    assign w_step = (r_cnt == '0) ? in_step : r_step;

    mpp_quant1 u_q0 (.i_x(in_c0), .i_mp(w_mp), .i_step(w_step), .o_q(w_q0), .o_rec(w_rec0));
    mpp_quant1 u_q1 (.i_x(in_c1), .i_mp(w_mp), .i_step(w_step), .o_q(w_q1), .o_rec(w_rec1));
    mpp_quant1 u_q2 (.i_x(in_c2), .i_mp(w_mp), .i_step(w_step), .o_q(w_q2), .o_rec(w_rec2));

    // Merge the live last pixel into the working arrays and scatter into substreams.
    always_comb begin
        for (int i = 0; i < BLK_PIX - 1; i++) begin
            w_m0[i] = r_wc0[i];
            w_m1[i] = r_wc1[i];
            w_m2[i] = r_wc2[i];
        end
        w_m0[BLK_PIX-1] = w_q0;
        w_m1[BLK_PIX-1] = w_q1;
        w_m2[BLK_PIX-1] = w_q2;
        for (int j = 0; j < SSM_SAMPLES; j++) begin
            w_s0[j] = '0;
            w_s1[j] = '0;
            w_s2[j] = '0;
            w_s3[j] = '0;
        end
        for (int j = 0; j < SSM0_PIX; j++) begin
            w_s0[j]              = w_m0[j];
            w_s0[SSM0_PIX + j]   = w_m1[j];
            w_s0[2*SSM0_PIX + j] = w_m2[j];
        end
        for (int j = 0; j < SSMK_PIX; j++) begin
            w_s1[j] = w_m0[SSM0_PIX + j];
            w_s2[j] = w_m1[SSM0_PIX + j];
            w_s3[j] = w_m2[SSM0_PIX + j];
        end
    end

    // Pixel counter, block parameter latch and working-array writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_mp   <= '0;
            r_step <= '0;
            for (int i = 0; i < BLK_PIX - 1; i++) begin
                r_wc0[i] <= '0;
                r_wc1[i] <= '0;
                r_wc2[i] <= '0;
            end
        end else if (w_acc) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            if (r_cnt == '0) begin
                r_mp   <= in_mp;
                r_step <= in_step;
            end
            if (!w_last) begin
                r_wc0[r_cnt] <= w_q0;
                r_wc1[r_cnt] <= w_q1;
                r_wc2[r_cnt] <= w_q2;
            end
        end
    end

    // Registered reconstruction, one pulse per accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_valid <= 1'b0;
            rec_c0    <= '0;
            rec_c1    <= '0;
            rec_c2    <= '0;
        end else begin
            rec_valid <= w_acc;
            if (w_acc) begin
                rec_c0 <= w_rec0;
                rec_c1 <= w_rec1;
                rec_c2 <= w_rec2;
            end
        end
    end

    // Bundle register: loads on block completion (even while handing off the old one).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            for (int j = 0; j < SSM_SAMPLES; j++) begin
                mpp_qres_ssm0[j] <= '0;
                mpp_qres_ssm1[j] <= '0;
                mpp_qres_ssm2[j] <= '0;
                mpp_qres_ssm3[j] <= '0;
            end
        end else if (w_acc && w_last) begin
            r_out_valid <= 1'b1;
            for (int j = 0; j < SSM_SAMPLES; j++) begin
                mpp_qres_ssm0[j] <= w_s0[j];
                mpp_qres_ssm1[j] <= w_s1[j];
                mpp_qres_ssm2[j] <= w_s2[j];
                mpp_qres_ssm3[j] <= w_s3[j];
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_enc_mpp.sv
// Bench for enc_mpp: reference model feeds expected queues, a negedge monitor
// consumes them, and scenario tasks add targeted inline checks.
module tb_enc_mpp;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_c0, in_c1, in_c2, in_mp;
    logic [2:0] in_step;
    logic       rec_valid;
    logic [7:0] rec_c0, rec_c1, rec_c2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] mpp_qres_ssm0 [0:15];
    logic [7:0] mpp_qres_ssm1 [0:15];
    logic [7:0] mpp_qres_ssm2 [0:15];
    logic [7:0] mpp_qres_ssm3 [0:15];

    int total = 0;
    int bad   = 0;

    logic [23:0]  rec_q[$];
    logic [511:0] bun_q[$];

    int         m_cnt = 0;
    logic [7:0] m_mp  = 8'h00;
    logic [2:0] m_step = 3'd0;
    logic [7:0] m_q [0:2][0:15];

    enc_mpp dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_c0(in_c0), .in_c1(in_c1), .in_c2(in_c2),
        .in_mp(in_mp), .in_step(in_step),
        .rec_valid(rec_valid), .rec_c0(rec_c0), .rec_c1(rec_c1), .rec_c2(rec_c2),
        .out_valid(out_valid), .out_ready(out_ready),
        .mpp_qres_ssm0(mpp_qres_ssm0), .mpp_qres_ssm1(mpp_qres_ssm1),
        .mpp_qres_ssm2(mpp_qres_ssm2), .mpp_qres_ssm3(mpp_qres_ssm3)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference arithmetic in plain integers: returns {q, rec}.
    function automatic logic [15:0] model_px(input logic [7:0] x, input logic [7:0] mp,
                                             input logic [2:0] st);
        int r, m, q, lo, hi, rc;
        logic [7:0] qb, rb;
        r = int'(x) - int'(mp);
        m = (r < 0) ? -r : r;
        if (st != 0) m = (m + (1 << (st - 1))) >> st;
        q = (r < 0) ? -m : m;
        hi = (1 << (7 - st)) - 1;
        lo = -(1 << (7 - st));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        rc = q * (1 << st) + int'(mp);
        if (rc < 0) rc = 0;
        if (rc > 255) rc = 255;
        qb = q[7:0];
        rb = rc[7:0];
        return {qb, rb};
    endfunction

    // Model one accepted pixel: push expected reconstruction and, at block end, the bundle.
    task automatic model_accept(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                                input logic [7:0] mp, input logic [2:0] st);
        logic [15:0]  p0, p1, p2;
        logic [511:0] b;
        if (m_cnt == 0) begin
            m_mp   = mp;
            m_step = st;
        end
        p0 = model_px(c0, m_mp, m_step);
        p1 = model_px(c1, m_mp, m_step);
        p2 = model_px(c2, m_mp, m_step);
        rec_q.push_back({p0[7:0], p1[7:0], p2[7:0]});
        m_q[0][m_cnt] = p0[15:8];
        m_q[1][m_cnt] = p1[15:8];
        m_q[2][m_cnt] = p2[15:8];
        if (m_cnt == 15) begin
            b = '0;
            for (int j = 0; j < 4; j++) begin
                b[j*8 +: 8]       = m_q[0][j];
                b[(4+j)*8 +: 8]   = m_q[1][j];
                b[(8+j)*8 +: 8]   = m_q[2][j];
            end
            for (int j = 0; j < 12; j++) begin
                b[(16+j)*8 +: 8]  = m_q[0][j+4];
                b[(32+j)*8 +: 8]  = m_q[1][j+4];
                b[(48+j)*8 +: 8]  = m_q[2][j+4];
            end
            bun_q.push_back(b);
        end
        m_cnt = (m_cnt + 1) % 16;
    endtask

    function automatic logic [511:0] dut_bundle();
        logic [511:0] b;
        for (int j = 0; j < 16; j++) begin
            b[j*8 +: 8]      = mpp_qres_ssm0[j];
            b[(16+j)*8 +: 8] = mpp_qres_ssm1[j];
            b[(32+j)*8 +: 8] = mpp_qres_ssm2[j];
            b[(48+j)*8 +: 8] = mpp_qres_ssm3[j];
        end
        return b;
    endfunction

    // Scoreboard monitor: pops expected results as the DUT produces them.
    always @(negedge clk) begin : monitor
        logic [23:0]  er;
        logic [511:0] eb;
        if (rst === 1'b0 && rec_valid === 1'b1) begin
            total++;
            if (rec_q.size() == 0) begin
                bad++;
                $display("FAIL rec_unexpected: got %h expected no pixel", {rec_c0, rec_c1, rec_c2});
            end else begin
                er = rec_q.pop_front();
                if ({rec_c0, rec_c1, rec_c2} !== er) begin
                    bad++;
                    $display("FAIL rec_pixel: got %h expected %h", {rec_c0, rec_c1, rec_c2}, er);
                end
            end
        end
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (bun_q.size() == 0) begin
                bad++;
                $display("FAIL bundle_unexpected: got %h expected no bundle", dut_bundle());
            end else begin
                eb = bun_q.pop_front();
                if (dut_bundle() !== eb) begin
                    bad++;
                    $display("FAIL bundle: got %h expected %h", dut_bundle(), eb);
                end
            end
        end
    end

    // Driver: present one pixel and hold until accepted (bounded).
    task automatic send_pixel(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                              input logic [7:0] mp, input logic [2:0] st);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_c0 = c0; in_c1 = c1; in_c2 = c2; in_mp = mp; in_step = st;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
        end else begin
            model_accept(c0, c1, c2, mp, st);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_random(input int n, input logic [7:0] mp, input logic [2:0] st);
        for (int i = 0; i < n; i++) begin
            send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), mp, st);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_c0 = '0; in_c1 = '0; in_c2 = '0; in_mp = '0; in_step = '0;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL reset_rec_valid: got %b expected 0", rec_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        total++; if ({rec_c0, rec_c1, rec_c2} !== 24'h0) begin bad++; $display("FAIL reset_rec: got %h expected 000000", {rec_c0, rec_c1, rec_c2}); end
        total++; if (dut_bundle() !== 512'h0) begin bad++; $display("FAIL reset_bundle: got %h expected 0", dut_bundle()); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_uniform();
        for (int i = 0; i < 15; i++) send_pixel(8'h90, 8'h90, 8'h90, 8'h84, 3'd2);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL uniform_early_valid: got %b expected 0", out_valid); end
        @(posedge clk); #1;
        send_pixel(8'h90, 8'h90, 8'h90, 8'h84, 3'd2);
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL uniform_out_valid: got %b expected 1", out_valid); end
        total++; if (rec_c0 !== 8'h90) begin bad++; $display("FAIL uniform_rec: got %h expected 90", rec_c0); end
        total++; if (mpp_qres_ssm0[0] !== 8'h03 || mpp_qres_ssm0[11] !== 8'h03) begin bad++; $display("FAIL uniform_ssm0: got %h/%h expected 03/03", mpp_qres_ssm0[0], mpp_qres_ssm0[11]); end
        total++; if (mpp_qres_ssm0[12] !== 8'h00 || mpp_qres_ssm3[12] !== 8'h00) begin bad++; $display("FAIL uniform_pad: got %h/%h expected 00/00", mpp_qres_ssm0[12], mpp_qres_ssm3[12]); end
        total++; if (mpp_qres_ssm1[0] !== 8'h03 || mpp_qres_ssm3[11] !== 8'h03) begin bad++; $display("FAIL uniform_ssmk: got %h/%h expected 03/03", mpp_qres_ssm1[0], mpp_qres_ssm3[11]); end
        @(posedge clk); #1;
    endtask

    task automatic test_clip();
        send_pixel(8'h00, 8'hFF, 8'h90, 8'h84, 3'd2);
        @(negedge clk);
        total++; if ({rec_c0, rec_c1, rec_c2} !== 24'h04FF90) begin bad++; $display("FAIL clip_rec: got %h expected 04ff90", {rec_c0, rec_c1, rec_c2}); end
        @(posedge clk); #1;
        for (int i = 1; i < 16; i++)
            send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        @(negedge clk);
        total++; if (mpp_qres_ssm0[0] !== 8'hE0) begin bad++; $display("FAIL clip_low_q: got %h expected e0", mpp_qres_ssm0[0]); end
        total++; if (mpp_qres_ssm0[4] !== 8'h1F) begin bad++; $display("FAIL clip_high_q: got %h expected 1f", mpp_qres_ssm0[4]); end
        total++; if (mpp_qres_ssm0[8] !== 8'h03) begin bad++; $display("FAIL clip_mid_q: got %h expected 03", mpp_qres_ssm0[8]); end
        @(posedge clk); #1;
    endtask

    task automatic test_step0();
        send_pixel(8'hFF, 8'h00, 8'h80, 8'h00, 3'd0);
        @(negedge clk);
        total++; if ({rec_c0, rec_c1, rec_c2} !== 24'h7F007F) begin bad++; $display("FAIL step0_rec: got %h expected 7f007f", {rec_c0, rec_c1, rec_c2}); end
        @(posedge clk); #1;
        send_random(15, 8'h55, 3'd6);
        @(negedge clk);
        total++; if (mpp_qres_ssm0[0] !== 8'h7F || mpp_qres_ssm0[8] !== 8'h7F) begin bad++; $display("FAIL step0_q: got %h/%h expected 7f/7f", mpp_qres_ssm0[0], mpp_qres_ssm0[8]); end
        @(posedge clk); #1;
    endtask

    task automatic test_mapping();
        for (int i = 0; i < 16; i++) send_pixel(8'(i), 8'(8'h40 + i), 8'(8'h80 + i), 8'h00, 3'd0);
        @(negedge clk);
        total++; if (mpp_qres_ssm0[4] !== 8'h40) begin bad++; $display("FAIL map_ssm0_4: got %h expected 40", mpp_qres_ssm0[4]); end
        total++; if (mpp_qres_ssm2[0] !== 8'h44) begin bad++; $display("FAIL map_ssm2_0: got %h expected 44", mpp_qres_ssm2[0]); end
        total++; if (mpp_qres_ssm0[3] !== 8'h03) begin bad++; $display("FAIL map_ssm0_3: got %h expected 03", mpp_qres_ssm0[3]); end
        total++; if (mpp_qres_ssm1[11] !== 8'h0F) begin bad++; $display("FAIL map_last_pixel: got %h expected 0f", mpp_qres_ssm1[11]); end
        total++; if (mpp_qres_ssm3[0] !== 8'h7F) begin bad++; $display("FAIL map_ssm3_0: got %h expected 7f", mpp_qres_ssm3[0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] c0, c1, c2;
        out_ready = 1'b0;
        send_random(16, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        for (int i = 0; i < 15; i++) begin
            send_random(1, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
            @(negedge clk);
            total++;
            if (bun_q.size() == 0 || dut_bundle() !== bun_q[0]) begin
                bad++;
                $display("FAIL hold_stable: got %h expected held block-1 bundle", dut_bundle());
            end
            @(posedge clk); #1;
        end
        c0 = 8'($urandom_range(0, 255)); c1 = 8'($urandom_range(0, 255)); c2 = 8'($urandom_range(0, 255));
        in_valid = 1'b1; in_c0 = c0; in_c1 = c1; in_c2 = c2; in_mp = 8'hAA; in_step = 3'd7;
        repeat (3) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready: got %b expected 0", in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_out_valid: got %b expected 1", out_valid); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end else begin
            model_accept(c0, c1, c2, 8'hAA, 3'd7);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL back_to_back_valid: got %b expected 1", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_block();
        out_ready = 1'b0;
        send_pixel(8'hFF, 8'h10, 8'h20, 8'h00, 3'd0);
        send_random(15, 8'h30, 3'd1);
        send_random(7, 8'h60, 3'd3);
        rst = 1'b1;
        rec_q.delete();
        bun_q.delete();
        m_cnt = 0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL midrst_rec_valid: got %b expected 0", rec_valid); end
        total++; if (mpp_qres_ssm0[0] !== 8'h00) begin bad++; $display("FAIL midrst_bundle: got %h expected 00", mpp_qres_ssm0[0]); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       (i == 0) ? 8'h7B : 8'($urandom_range(0, 255)), (i == 0) ? 3'd4 : 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_clip();
        test_step0();
        test_mapping();
        test_back_to_back();
        test_reset_mid_block();
        repeat (4) @(negedge clk);
        total++; if (rec_q.size() != 0) begin bad++; $display("FAIL rec_drain: got %0d pending expected 0", rec_q.size()); end
        total++; if (bun_q.size() != 0) begin bad++; $display("FAIL bundle_drain: got %0d pending expected 0", bun_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
